// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round/width constants, controller state
// encoding, the S-box and round-constant tables, and the GF(2^8) doubling
// helper used by MixColumns.
// Byte order throughout: byte i of a 128-bit [0:127] vector is bits
// [8*i : 8*i+7], column-major (byte = row + 4*column).
package aes_pkg;

   localparam int NR = 10;
   localparam int DW = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aes_state_e;

   // S-box, entry x at bits [8*x : 8*x+7]
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Round constants for rounds 1..10
   localparam logic [0:79] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   // Multiply by {02} in GF(2^8)
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Round constant for round r (1..10); zero outside that range
   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      logic [7:0] rc;
      if ((r >= 4'd1) && (r <= 4'd10)) begin
         rc = RCON[{r - 4'd1, 3'b000} +: 8];
      end else begin
         rc = 8'h00;
      end
      return rc;
   endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step (combinational).
// Ports:
//   key      [0:127] current round key
//   rcon     [7:0]   round constant for the step
//   next_key [0:127] following round key
module aes_key_round
   import aes_pkg::*;
(
   input  logic [0:127] key,
   input  logic [7:0]   rcon,
   output logic [0:127] next_key
);

   logic [0:31] temp_s;
   logic [0:31] n0_s, n1_s, n2_s, n3_s;

   // RotWord + SubWord of the last word, round constant on its first byte
   assign temp_s = {sbox(key[104:111]) ^ rcon, sbox(key[112:119]),
                    sbox(key[120:127]), sbox(key[96:103])};

   assign n0_s = key[0:31]   ^ temp_s;
   assign n1_s = key[32:63]  ^ n0_s;
   assign n2_s = key[64:95]  ^ n1_s;
   assign n3_s = key[96:127] ^ n2_s;

   assign next_key = {n0_s, n1_s, n2_s, n3_s};

endmodule

// File: rtl/mixColumns.sv
// AES MixColumns over a full column-major 128-bit state (combinational).
// Ports:
//   state_in  [0:127] state before MixColumns
//   state_out [0:127] state after MixColumns
module mixColumns
   import aes_pkg::*;
(
   input  logic [0:127] state_in,
   output logic [0:127] state_out
);

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0_s, a1_s, a2_s, a3_s;
      assign a0_s = state_in[32*c      +: 8];
      assign a1_s = state_in[32*c + 8  +: 8];
      assign a2_s = state_in[32*c + 16 +: 8];
      assign a3_s = state_in[32*c + 24 +: 8];
      // {03}*x is xtime(x) ^ x
      assign state_out[32*c      +: 8] = xtime(a0_s) ^ xtime(a1_s) ^ a1_s ^ a2_s ^ a3_s;
      assign state_out[32*c + 8  +: 8] = a0_s ^ xtime(a1_s) ^ xtime(a2_s) ^ a2_s ^ a3_s;
      assign state_out[32*c + 16 +: 8] = a0_s ^ a1_s ^ xtime(a2_s) ^ xtime(a3_s) ^ a3_s;
      assign state_out[32*c + 24 +: 8] = xtime(a0_s) ^ a0_s ^ a1_s ^ a2_s ^ xtime(a3_s);
   end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one full round per clock on a
// shared round datapath, round keys generated on the fly, one block in flight.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    plaintext+key handshake (in_data, in_key)
//   out_valid/out_ready  ciphertext handshake (out_data)
//   busy                 high while a block is being processed or held
//   round_idx            current round 1..10, 0 otherwise
// Build option: AES_BACK2BACK_EN lets a new block load in the same cycle
// the finished one is taken (in_ready then follows out_ready in DONE).
module aes128_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR = aes_pkg::NR,
   parameter int DW = aes_pkg::DW
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [0:DW-1] in_data,
   input  logic [0:DW-1] in_key,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [0:DW-1] out_data,
   output logic          busy,
   output logic [3:0]    round_idx
);

   if ((NR != 32'd10) || (DW != 32'd128)) begin : g_bad_cfg
      $error("aes128_round_ctrl supports only NR=10 and DW=128");
   end

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   aes_state_e   state_q, state_d;
   logic [0:127] blk_q, blk_d;
   logic [0:127] key_q, key_d;
   logic [3:0]   round_q, round_d;

   logic [0:127] sr_s, mc_s, rk_s, rnd_s, load_blk_s;

   // SubBytes fused with ShiftRows: output (row, col) reads (row, col+row mod 4)
   for (genvar i = 0; i < 16; i++) begin : g_sub_shift
      localparam int ROW = i % 4;
      localparam int SRC = ROW + 4 * (((i / 4) + ROW) % 4);
      assign sr_s[8*i +: 8] = sbox(blk_q[8*SRC +: 8]);
   end

   mixColumns u_mix (
      .state_in  (sr_s),
      .state_out (mc_s)
   );

   aes_key_round u_key (
      .key      (key_q),
      .rcon     (rcon_of(round_q)),
      .next_key (rk_s)
   );

   // Final round skips MixColumns
   assign rnd_s      = ((round_q == LAST_ROUND) ? sr_s : mc_s) ^ rk_s;
   assign load_blk_s = in_data ^ in_key;
   assign round_idx  = round_q;

   // State, block and key registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         blk_q   <= 128'h0;
         key_q   <= 128'h0;
         round_q <= 4'd0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         key_q   <= key_d;
         round_q <= round_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      blk_d     = blk_q;
      key_d     = key_q;
      round_d   = round_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_data  = 128'h0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               blk_d   = load_blk_s;
               key_d   = in_key;
               round_d = 4'd1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            busy  = 1'b1;
            blk_d = rnd_s;
            key_d = rk_s;
            if (round_q == LAST_ROUND) begin
               round_d = 4'd0;
               state_d = DONE;
            end else begin
               round_d = round_q + 4'd1;
               state_d = RUN;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = blk_q;
`ifdef AES_BACK2BACK_EN
            in_ready = out_ready;
            if (out_ready && in_valid) begin
               blk_d   = load_blk_s;
               key_d   = in_key;
               round_d = 4'd1;
               state_d = RUN;
            end else if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
`else
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            round_d = 4'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: FIPS-197 vectors, latency,
// round sequencing, backpressure, busy-ignore, mid-run reset, random blocks
// against an independent AES model, and back-to-back streaming.
module tb_aes128_round_ctrl;

   logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
   logic [0:127] in_data, in_key, out_data;
   logic [3:0]   round_idx;
   int           errors = 0;
   int           checks = 0;
   logic [7:0]   sb [0:255];

   localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_BACK2BACK_EN
   localparam int B2B_GAP = 11;
`else
   localparam int B2B_GAP = 12;
`endif

   aes128_round_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .round_idx (round_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] x);
      return {x[6:0], x[7]};
   endfunction

   // S-box from its definition: multiplicative inverse then affine map
   task automatic build_sbox();
      logic [7:0] inv, r1, r2, r3, r4;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
         sb[a] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
      end
   endtask

   function automatic logic [0:127] aes_model(input logic [0:127] pt, input logic [0:127] key);
      logic [7:0]   st [0:15];
      logic [7:0]   k  [0:15];
      logic [7:0]   t  [0:15];
      logic [7:0]   rc, a0, a1, a2, a3, w0, w1, w2, w3;
      logic [0:127] res;
      for (int i = 0; i < 16; i++) begin
         k[i]  = key[8*i +: 8];
         st[i] = pt[8*i +: 8] ^ k[i];
      end
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         w0 = sb[k[13]] ^ rc; w1 = sb[k[14]]; w2 = sb[k[15]]; w3 = sb[k[12]];
         k[0] ^= w0; k[1] ^= w1; k[2] ^= w2; k[3] ^= w3;
         for (int j = 4; j < 16; j++) k[j] ^= k[j-4];
         rc = gmul(rc, 8'h02);
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
               t[rw + 4*c] = sb[st[rw + 4*((c + rw) % 4)]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r < 10) begin
               st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
               st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
            end
         end
         for (int j = 0; j < 16; j++) st[j] ^= k[j];
      end
      for (int i = 0; i < 16; i++) res[8*i +: 8] = st[i];
      return res;
   endfunction

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a block from IDLE; accepted at the next edge, then inputs are scrambled
   task automatic send(input logic [0:127] pt, input logic [0:127] key);
      in_data  = pt;
      in_key   = key;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = 128'h0; in_key = 128'h0;
      #12;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (round_idx !== 4'd0) begin errors++; $display("FAIL reset_round_idx: got %0d expected 0", round_idx); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fips_c1();
      int lat;
      lat = -1;
      out_ready = 1'b1;
      send(C1_PT, C1_KEY);
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         tick();
         if (out_valid) lat = n;
      end
      checks++; if (lat != 10) begin errors++; $display("FAIL c1_latency: got %0d expected 10", lat); end
      checks++; if (out_data !== C1_CT) begin errors++; $display("FAIL c1_data: got %h expected %h", out_data, C1_CT); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL c1_pulse_width: out_valid got %b expected 0", out_valid); end
   endtask

   task automatic test_fips_b();
      int exp_r;
      out_ready = 1'b1;
      send(B_PT, B_KEY);
      checks++; if (round_idx !== 4'd1) begin errors++; $display("FAIL b_round_first: got %0d expected 1", round_idx); end
      for (int n = 1; n <= 10; n++) begin
         tick();
         exp_r = (n < 10) ? n + 1 : 0;
         checks++; if (round_idx !== 4'(exp_r)) begin errors++; $display("FAIL b_round_step%0d: got %0d expected %0d", n, round_idx, exp_r); end
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b_out_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== B_CT) begin errors++; $display("FAIL b_data: got %h expected %h", out_data, B_CT); end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(C1_PT, C1_KEY);
      repeat (10) tick();
      for (int n = 0; n < 20; n++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== C1_CT || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                     n, out_valid, in_ready, out_data, C1_CT);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_busy_ignore();
      int           n_out;
      logic         acc;
      logic [0:127] outs [0:1];
      n_out = 0;
      outs[0] = 128'h0; outs[1] = 128'h0;
      out_ready = 1'b1;
      send(C1_PT, C1_KEY);
      repeat (4) tick();
      checks++; if (round_idx !== 4'd5) begin errors++; $display("FAIL busy_round5: got %0d expected 5", round_idx); end
      in_data = B_PT; in_key = B_KEY; in_valid = 1'b1;
      for (int n = 0; n < 40 && n_out < 2; n++) begin
         if (out_valid) begin
            outs[n_out] = out_data;
            n_out++;
         end else if (n_out == 0) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %b expected 0", in_ready); end
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      tick();
      checks++; if (n_out != 2) begin errors++; $display("FAIL busy_out_count: got %0d expected 2", n_out); end
      checks++; if (outs[0] !== C1_CT) begin errors++; $display("FAIL busy_first: got %h expected %h", outs[0], C1_CT); end
      checks++; if (outs[1] !== B_CT) begin errors++; $display("FAIL busy_second: got %h expected %h", outs[1], B_CT); end
   endtask

   task automatic test_reset_midrun();
      int lat;
      lat = -1;
      out_ready = 1'b1;
      send(C1_PT, C1_KEY);
      repeat (3) tick();
      checks++; if (round_idx !== 4'd4) begin errors++; $display("FAIL mr_round4: got %0d expected 4", round_idx); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          round_idx !== 4'd0 || out_data !== 128'h0) begin
         errors++;
         $display("FAIL mr_reset_outputs: in_ready=%b out_valid=%b busy=%b round=%0d data=%h expected 1 0 0 0 0",
                  in_ready, out_valid, busy, round_idx, out_data);
      end
      #2;
      rst_n = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_no_stale: got %b expected 0", out_valid); end
      send(B_PT, B_KEY);
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         tick();
         if (out_valid) lat = n;
      end
      checks++; if (lat != 10) begin errors++; $display("FAIL mr_latency: got %0d expected 10", lat); end
      checks++; if (out_data !== B_CT) begin errors++; $display("FAIL mr_data: got %h expected %h", out_data, B_CT); end
      tick();
   endtask

   task automatic test_random();
      logic [0:127] pt, key, exp_ct;
      int           lat, hold;
      for (int b = 0; b < 8; b++) begin
         pt     = {$urandom(), $urandom(), $urandom(), $urandom()};
         key    = {$urandom(), $urandom(), $urandom(), $urandom()};
         exp_ct = aes_model(pt, key);
         hold   = $urandom_range(0, 3);
         lat    = -1;
         out_ready = 1'b0;
         send(pt, key);
         for (int n = 1; n <= 20 && lat < 0; n++) begin
            tick();
            if (out_valid) lat = n;
         end
         checks++; if (lat != 10) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 10", b, lat); end
         repeat (hold) tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_ct) begin
            errors++;
            $display("FAIL rnd%0d_data: valid=%b got %h expected %h", b, out_valid, out_data, exp_ct);
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_release: got %b expected 0", b, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      int           nacc, nout;
      int           t_out [0:1];
      logic [0:127] d_out [0:1];
      logic         acc;
      nacc = 0; nout = 0;
      t_out[0] = 0; t_out[1] = 0;
      d_out[0] = 128'h0; d_out[1] = 128'h0;
      out_ready = 1'b1;
      in_data = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
      for (int n = 0; n < 60 && nout < 2; n++) begin
         if (out_valid) begin
            t_out[nout] = n;
            d_out[nout] = out_data;
            nout++;
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            nacc++;
            if (nacc == 1) begin
               in_data = B_PT; in_key = B_KEY;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (nout != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", nout); end
      checks++; if (d_out[0] !== C1_CT) begin errors++; $display("FAIL b2b_first: got %h expected %h", d_out[0], C1_CT); end
      checks++; if (d_out[1] !== B_CT) begin errors++; $display("FAIL b2b_second: got %h expected %h", d_out[1], B_CT); end
      checks++; if (t_out[1] - t_out[0] != B2B_GAP) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", t_out[1] - t_out[0], B2B_GAP); end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_backpressure();
      test_busy_ignore();
      test_reset_midrun();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
